spi_cmd_master: RTL

- Host-side SPI command transmitter; directly upstream of the SPI register block.
- Serialises one command frame (4-bit command then LEN data bits, MSB first) onto o_sclk/o_ss_n/o_mosi, in the exact format the register block's receiver decodes.
- Used in FPGA builds (driven by buttons or a debug UART) and as the stimulus driver in the top-level bench.

---
 rtl/spi_cmd_master_pkg.sv | 55 +++++
 rtl/spi_cmd_master_phase_timer.sv | 31 +++
 rtl/spi_cmd_master.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/spi_cmd_master_pkg.sv
// Shared SPI command frame definitions: command codes, payload lengths and
// helpers for building the serial frame. The register block uses the same set.
package spi_cmd_master_pkg;

  localparam int SPI_CMD_BITS    = 4;
  localparam int SPI_BUFFER_SIZE = 12;
  localparam int SPI_FRAME_MAX   = SPI_CMD_BITS + SPI_BUFFER_SIZE;

  typedef enum logic [3:0] {
    CMD_SKY    = 4'd0,
    CMD_FLOOR  = 4'd1,
    CMD_LEAK   = 4'd2,
    CMD_OTHER  = 4'd3,
    CMD_VSHIFT = 4'd4,
    CMD_VINF   = 4'd5
  } spi_cmd_e;

  localparam logic [3:0] LEN_SKY    = 4'd6;
  localparam logic [3:0] LEN_FLOOR  = 4'd6;
  localparam logic [3:0] LEN_LEAK   = 4'd6;
  localparam logic [3:0] LEN_OTHER  = 4'd12;
  localparam logic [3:0] LEN_VSHIFT = 4'd6;
  localparam logic [3:0] LEN_VINF   = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // Payload length for a command; zero marks an invalid code.
  function automatic logic [3:0] spi_len(input logic [3:0] cmd);
    case (cmd)
      CMD_SKY:    return LEN_SKY;
      CMD_FLOOR:  return LEN_FLOOR;
      CMD_LEAK:   return LEN_LEAK;
      CMD_OTHER:  return LEN_OTHER;
      CMD_VSHIFT: return LEN_VSHIFT;
      CMD_VINF:   return LEN_VINF;
      default:    return 4'd0;
    endcase
  endfunction

  // MSB-aligned frame: command nibble, then the low LEN payload bits.
  function automatic logic [SPI_FRAME_MAX-1:0] spi_frame(input logic [3:0]  cmd,
                                                         input logic [11:0] data);
    logic [SPI_BUFFER_SIZE-1:0] d;
    d = data << (SPI_BUFFER_SIZE - int'(spi_len(cmd)));
    return {cmd, d};
  endfunction

endpackage

// File: rtl/spi_cmd_master_phase_timer.sv
// Loadable down-counter pacing every SPI phase; tc_o is high on the last
// cycle of a SCLK_DIV-long phase.
module spi_phase_timer #(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic tc_o
);

  localparam logic [7:0] RELOAD = 8'(SCLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = RELOAD;
    else if (cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_cmd_master.sv
// Host-side SPI command transmitter: serialises a 4-bit command plus LEN
// payload bits, MSB first, with SCLK_DIV-paced setup/hold/gap phases.
module spi_cmd_master
  import spi_cmd_master_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [3:0]  i_cmd,
  input  logic [11:0] i_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_sclk,
  output logic        o_ss_n,
  output logic        o_mosi
);

  if (SCLK_DIV < 2 || SCLK_DIV > 255) begin : g_bad_div
    $error("spi_cmd_master: SCLK_DIV must be in 2..255");
  end

  spi_state_e state_q, state_d;

  logic [SPI_FRAME_MAX-2:0] sr_q, sr_d;   // bits still to send after the one on o_mosi
  logic [4:0]               bits_q, bits_d;
  logic sclk_q, sclk_d, ss_n_q, ss_n_d, mosi_q, mosi_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic                     tc, timer_load, accept, reject, last_bit;
  logic [3:0]               len_in;
  logic [SPI_FRAME_MAX-1:0] frame_in;

  assign len_in   = spi_len(i_cmd);
  assign frame_in = spi_frame(i_cmd, i_data);
  // The o_done cycle still reads as IDLE, so it must explicitly block starts.
  assign accept   = (state_q == ST_IDLE) && i_start && !done_q && (len_in != 4'd0);
  assign reject   = (state_q == ST_IDLE) && i_start && !done_q && (len_in == 4'd0);
  assign last_bit = (bits_q == 5'd1);
  assign timer_load = accept || ((state_q != ST_IDLE) && tc);

  spi_phase_timer #(.SCLK_DIV(SCLK_DIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (timer_load),
    .tc_o   (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (tc) state_d = ST_HIGH;
      ST_HIGH:  if (tc) state_d = last_bit ? ST_HOLD : ST_LOW;
      ST_LOW:   if (tc) state_d = ST_HIGH;
      ST_HOLD:  if (tc) state_d = ST_GAP;
      ST_GAP:   if (tc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sr_d   = sr_q;
    bits_d = bits_q;
    sclk_d = sclk_q;
    ss_n_d = ss_n_q;
    mosi_d = mosi_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
          ss_n_d = 1'b0;
          mosi_d = frame_in[SPI_FRAME_MAX-1];
          sr_d   = frame_in[SPI_FRAME_MAX-2:0];
          bits_d = 5'(len_in) + 5'(SPI_CMD_BITS);
        end else if (reject) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      ST_SETUP: if (tc) sclk_d = 1'b1;
      ST_HIGH: begin
        if (tc) begin
          sclk_d = 1'b0;
          if (!last_bit) begin
            mosi_d = sr_q[SPI_FRAME_MAX-2];
            sr_d   = {sr_q[SPI_FRAME_MAX-3:0], 1'b0};
            bits_d = bits_q - 5'd1;
          end
        end
      end
      ST_LOW: if (tc) sclk_d = 1'b1;
      ST_HOLD: begin
        if (tc) begin
          ss_n_d = 1'b1;
          mosi_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (tc) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '0;
      bits_q <= '0;
      sclk_q <= 1'b0;
      ss_n_q <= 1'b1;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bits_q <= bits_d;
      sclk_q <= sclk_d;
      ss_n_q <= ss_n_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign o_sclk = sclk_q;
  assign o_ss_n = ss_n_q;
  assign o_mosi = mosi_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_err  = err_q;

endmodule
